tsu_queue_reader: RTL

//  Read-side drain engine for the TSU timestamp queue. Pops one 128-bit

---
 rtl/tsu_queue_reader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tsu_queue_reader.sv
// TSU timestamp queue drain engine.
// Pops one 128-bit entry from the TSU queue whenever it is non-empty. The
// entry is sent out MSW first as four 32-bit words over a valid/ready stream.
//
// state  | meaning
// IDLE   | no entry in flight; pop when en && q_rd_stat != 0
// POP    | one-cycle q_rd_en strobe to the queue
// WAIT   | read latency; q_rd_data captured on the final cycle
// SEND   | present hold words 0..3, advance on out_valid & out_ready
module tsu_queue_reader #(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        q_rd_stat,
    output logic              q_rd_en,
    input  logic [127:0]      q_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  ts_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    // WAIT covers RD_LATENCY cycles; the down-counter starts at RD_LATENCY-1
    // so that terminal count marks the cycle on which q_rd_data is valid.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

    state_t             state_q, state_d;
    logic [1:0]         lat_q, lat_d;
    logic [127:0]       hold_q, hold_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    assign accept = (state_q == S_SEND) && out_ready;

    // State and datapath registers with synchronous reset; reset discards
    // any entry that was popped but not yet fully delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: pop, wait out read latency, capture, stream words.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (en && (q_rd_stat != 8'd0)) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 2'd0) begin
                    hold_d  = q_rd_data;
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_SEND: begin
                if (accept) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Word select from the hold register, most significant word first.
    always_comb begin
        out_data = 32'd0;
        if (state_q == S_SEND) begin
            case (idx_q)
                2'd0:    out_data = hold_q[127:96];
                2'd1:    out_data = hold_q[95:64];
                2'd2:    out_data = hold_q[63:32];
                default: out_data = hold_q[31:0];
            endcase
        end
    end

    assign q_rd_en   = (state_q == S_POP);
    assign out_valid = (state_q == S_SEND);
    assign out_last  = (state_q == S_SEND) && (idx_q == 2'd3);
    assign busy      = (state_q != S_IDLE);
    assign ts_cnt    = cnt_q;

endmodule
